mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM request arbiter and sequencer for the byte-serial memory controller
module mem_arbiter #(
  parameter int         MAX_MEM_BURST = 4,
  parameter logic [3:0] MEM_LW        = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        inst_flush,
  output logic        if_done,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_type,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        busy,
  output logic        mc_start,
  output logic        mc_sel,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [3:0]  mc_type,
  input  logic        mc_ready,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  localparam int SW = $clog2(MAX_MEM_BURST + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          drop;
  logic          if_ok;
  logic          grant_mem;
  logic          grant_if;

  // A flushed fetch is not a candidate; IF is forced once MEM has won MAX_MEM_BURST times in a row.
  assign if_ok     = if_req & ~inst_flush;
  assign grant_mem = mem_req & (~if_ok | (streak != SW'(MAX_MEM_BURST)));
  assign grant_if  = if_ok & ~grant_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      streak    <= '0;
      drop      <= 1'b0;
      if_done   <= 1'b0;
      if_pc     <= '0;
      if_inst   <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      busy      <= 1'b0;
      mc_start  <= 1'b0;
      mc_sel    <= 1'b0;
      mc_addr   <= '0;
      mc_wdata  <= '0;
      mc_type   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_mem || grant_if) begin
            mc_sel   <= grant_mem;
            mc_addr  <= grant_mem ? mem_addr : if_addr;
            mc_wdata <= grant_mem ? mem_wdata : 32'd0;
            mc_type  <= grant_mem ? mem_type : MEM_LW;
            if (grant_mem && if_ok)
              streak <= (streak == SW'(MAX_MEM_BURST)) ? streak : streak + 1'b1;
            else
              streak <= '0;
            busy <= 1'b1;
            drop <= 1'b0;
            if (mc_ready) begin
              mc_start <= 1'b1;
              state    <= WAIT;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!mc_sel && inst_flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (mc_ready) begin
            mc_start <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          mc_start <= 1'b0;
          if (mc_done) begin
            // A flush sampled together with the completion still kills the fetch.
            if (mc_sel) begin
              mem_done  <= 1'b1;
              mem_rdata <= mc_rdata;
            end else if (!drop && !inst_flush) begin
              if_done <= 1'b1;
              if_inst <= mc_rdata;
              if_pc   <= mc_addr;
            end
            drop  <= 1'b0;
            state <= DONE;
          end else if (!mc_sel && inst_flush) begin
            drop <= 1'b1;
          end
        end
        DONE: begin
          if_done  <= 1'b0;
          mem_done <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter
module tb_mem_arbiter;

  localparam logic [3:0] T_LW = 4'd2;
  localparam logic [3:0] T_SW = 4'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        inst_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        mem_req = 1'b0;
  logic [31:0] mem_addr = 32'h2000;
  logic [31:0] mem_wdata = 32'hDEADBEEF;
  logic [3:0]  mem_type = T_SW;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        mc_start;
  logic        mc_sel;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic [3:0]  mc_type;
  logic        mc_ready = 1'b0;
  logic        mc_done = 1'b0;
  logic [31:0] mc_rdata = '0;

  int total = 0;
  int bad = 0;

  mem_arbiter #(.MAX_MEM_BURST(4), .MEM_LW(T_LW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .inst_flush(inst_flush),
    .if_done(if_done), .if_pc(if_pc), .if_inst(if_inst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_type(mem_type),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy),
    .mc_start(mc_start), .mc_sel(mc_sel), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_type(mc_type), .mc_ready(mc_ready), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        fl;
    logic        mr;
    logic        rdy;
    logic        dn;
    logic [31:0] rd;
    logic [4:0]  ex;   // {busy, mc_start, mc_sel, if_done, mem_done}
    logic [31:0] ea;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[29];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_req = 1'b0; mem_req = 1'b0; inst_flush = 1'b0;
    mc_ready = 1'b0; mc_done = 1'b0; mc_rdata = '0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  function automatic logic any_out();
    return |{if_done, if_pc, if_inst, mem_done, mem_rdata, busy,
             mc_start, mc_sel, mc_addr, mc_wdata, mc_type};
  endfunction

  initial begin
    int cnt;
    logic [9:0] order;
    int exp_streak[10];

    tbl[0]  = '{1, 32'h100, 0, 0, 1, 0, 32'h0,        5'b11000, 32'h100,  32'h0};
    tbl[1]  = '{1, 32'h100, 0, 0, 1, 0, 32'h0,        5'b10000, 32'h100,  32'h0};
    tbl[2]  = '{1, 32'h100, 0, 0, 1, 0, 32'h0,        5'b10000, 32'h100,  32'h0};
    tbl[3]  = '{1, 32'h100, 0, 0, 1, 0, 32'h0,        5'b10000, 32'h100,  32'h0};
    tbl[4]  = '{1, 32'h100, 0, 0, 1, 1, 32'h00A00093, 5'b10010, 32'h100,  32'h00A00093};
    tbl[5]  = '{0, 32'h100, 0, 1, 1, 1, 32'h0,        5'b00000, 32'h100,  32'h0};
    tbl[6]  = '{0, 32'h100, 0, 1, 1, 0, 32'h0,        5'b11100, 32'h2000, 32'h0};
    tbl[7]  = '{1, 32'h100, 0, 1, 1, 0, 32'h0,        5'b10100, 32'h2000, 32'h0};
    tbl[8]  = '{1, 32'h100, 0, 1, 1, 1, 32'h12345678, 5'b10101, 32'h2000, 32'h12345678};
    tbl[9]  = '{0, 32'h100, 0, 0, 1, 0, 32'h0,        5'b00100, 32'h2000, 32'h0};
    tbl[10] = '{1, 32'h100, 0, 0, 1, 0, 32'h0,        5'b11000, 32'h100,  32'h0};
    tbl[11] = '{1, 32'h100, 1, 0, 1, 0, 32'h0,        5'b10000, 32'h100,  32'h0};
    tbl[12] = '{0, 32'h100, 0, 0, 1, 0, 32'h0,        5'b10000, 32'h100,  32'h0};
    tbl[13] = '{0, 32'h100, 0, 0, 1, 1, 32'h00000BAD, 5'b10000, 32'h100,  32'h0};
    tbl[14] = '{0, 32'h100, 0, 0, 1, 0, 32'h0,        5'b00000, 32'h100,  32'h0};
    tbl[15] = '{1, 32'h200, 0, 0, 1, 0, 32'h0,        5'b11000, 32'h200,  32'h0};
    tbl[16] = '{1, 32'h200, 0, 0, 1, 1, 32'h00100073, 5'b10010, 32'h200,  32'h00100073};
    tbl[17] = '{0, 32'h200, 0, 0, 1, 0, 32'h0,        5'b00000, 32'h200,  32'h0};
    tbl[18] = '{1, 32'h300, 0, 0, 0, 0, 32'h0,        5'b10000, 32'h300,  32'h0};
    tbl[19] = '{1, 32'h300, 0, 0, 0, 0, 32'h0,        5'b10000, 32'h300,  32'h0};
    tbl[20] = '{1, 32'h300, 1, 0, 1, 0, 32'h0,        5'b00000, 32'h300,  32'h0};
    tbl[21] = '{0, 32'h300, 0, 0, 1, 0, 32'h0,        5'b00000, 32'h300,  32'h0};
    tbl[22] = '{1, 32'h400, 0, 0, 1, 0, 32'h0,        5'b11000, 32'h400,  32'h0};
    tbl[23] = '{1, 32'h400, 1, 0, 1, 1, 32'h1,        5'b10000, 32'h400,  32'h0};
    tbl[24] = '{0, 32'h400, 0, 0, 1, 0, 32'h0,        5'b00000, 32'h400,  32'h0};
    tbl[25] = '{1, 32'h400, 1, 1, 1, 0, 32'h0,        5'b11100, 32'h2000, 32'h0};
    tbl[26] = '{0, 32'h400, 0, 1, 1, 1, 32'h5,        5'b10101, 32'h2000, 32'h5};
    tbl[27] = '{0, 32'h400, 0, 0, 1, 0, 32'h0,        5'b00100, 32'h2000, 32'h0};
    tbl[28] = '{1, 32'h400, 1, 0, 1, 0, 32'h0,        5'b00100, 32'h2000, 32'h0};

    do_reset();
    #1;
    chk("reset_outputs", 32'(any_out()), 32'd0);

    for (int i = 0; i < 29; i++) begin
      if_req = tbl[i].ir; if_addr = tbl[i].ia; inst_flush = tbl[i].fl;
      mem_req = tbl[i].mr; mc_ready = tbl[i].rdy; mc_done = tbl[i].dn; mc_rdata = tbl[i].rd;
      cyc();
      chk($sformatf("row%0d_flags", i), 32'({busy, mc_start, mc_sel, if_done, mem_done}), 32'(tbl[i].ex));
      chk($sformatf("row%0d_mc_addr", i), mc_addr, tbl[i].ea);
      if (tbl[i].ex[1]) begin
        chk($sformatf("row%0d_if_inst", i), if_inst, tbl[i].ed);
        chk($sformatf("row%0d_if_pc", i), if_pc, tbl[i].ea);
      end
      if (tbl[i].ex[0]) chk($sformatf("row%0d_mem_rdata", i), mem_rdata, tbl[i].ed);
      if (i == 0) begin
        chk("fetch_mc_type", 32'(mc_type), 32'(T_LW));
        chk("fetch_mc_wdata", mc_wdata, 32'd0);
      end
      if (i == 6) begin
        chk("store_mc_type", 32'(mc_type), 32'(T_SW));
        chk("store_mc_wdata", mc_wdata, 32'hDEADBEEF);
      end
    end

    // Both requesters held continuously: MEM x4, IF, MEM x4, IF.
    do_reset();
    order = 10'b1111011110;
    exp_streak = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    if_addr = 32'h600; if_req = 1'b1; mem_req = 1'b1; mc_ready = 1'b1; mc_rdata = 32'h77;
    for (int g = 0; g < 10; g++) begin
      cnt = 0;
      cyc();
      while (!mc_start && cnt < 20) begin
        cyc();
        cnt++;
      end
      chk($sformatf("arb%0d_timeout", g), 32'(cnt < 20), 32'd1);
      chk($sformatf("arb%0d_sel", g), 32'(mc_sel), 32'(order[9-g]));
      chk($sformatf("arb%0d_streak", g), 32'(dut.streak), 32'(exp_streak[g]));
      mc_done = 1'b1;
      cyc();
      chk($sformatf("arb%0d_done", g), 32'({if_done, mem_done}), order[9-g] ? 32'd1 : 32'd2);
      mc_done = 1'b0;
    end

    // Reset while a fetch is in flight, then a late completion.
    do_reset();
    if_addr = 32'h500; if_req = 1'b1; mc_ready = 1'b1;
    cyc();
    chk("rstwait_start", 32'({busy, mc_start}), 32'd3);
    if_req = 1'b0;
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk("rstwait_outputs", 32'(any_out()), 32'd0);
    #1;
    rst = 1'b1;
    mc_done = 1'b1; mc_rdata = 32'hCAFE;
    cyc();
    mc_done = 1'b0;
    chk("late_done", 32'({busy, if_done, mem_done}), 32'd0);
    cyc();
    chk("late_done_idle", 32'({busy, mc_start, if_done, mem_done}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
